// File: rtl/hazard_ctrl_pkg.sv
// Shared types and constants for the decode-stage hazard controller.
// Latency: n/a (types, constants and one pure function only).
// Backpressure: n/a.
package hazard_ctrl_pkg;

    localparam int REG_W    = 3;
    localparam int NUM_REGS = 8;

    // One in-flight pipeline slot (EX, MEM or WB).
    typedef struct packed {
        logic             valid;
        logic             wr_en;
        logic [REG_W-1:0] wr;
        logic             is_load;
    } slot_t;

    // Operand source select driven to the EX-stage operand muxes.
    typedef enum logic [1:0] {
        FWD_RF  = 2'd0,
        FWD_EXM = 2'd1,
        FWD_MWB = 2'd2
    } fwd_sel_t;

    // A slot supplies a source only if it really writes the register the source really reads.
    function automatic logic slot_hit(input slot_t s, input logic used, input logic [REG_W-1:0] src);
        return s.valid & s.wr_en & used & (s.wr == src);
    endfunction

endpackage

// File: rtl/hazard_src_match.sv
// Per-source match against the EX/MEM/WB slots plus the operand forwarding select.
// Latency: purely combinational, zero cycles.
// Backpressure: none; the parent decides stall/issue from the hit bits.
// Build option: HAZARD_FORWARD_EN enables forwarding selects (otherwise tied to regfile).
module hazard_src_match
    import hazard_ctrl_pkg::*;
(
    input  logic [REG_W-1:0] src_i,
    input  logic             used_i,
    input  slot_t            ex_i,
    input  slot_t            mem_i,
    input  slot_t            wb_i,
    output logic             ex_hit_o,
    output logic             mem_hit_o,
    output logic             wb_hit_o,
    output logic [1:0]       fwd_sel_o
);

    assign ex_hit_o  = slot_hit(ex_i,  used_i, src_i);
    assign mem_hit_o = slot_hit(mem_i, used_i, src_i);
    assign wb_hit_o  = slot_hit(wb_i,  used_i, src_i);

`ifdef HAZARD_FORWARD_EN
    // Youngest writer wins; a load still in EX has no data yet, so fall through to MEM.
    always_comb begin
        fwd_sel_o = FWD_RF;
        if (ex_hit_o && !ex_i.is_load) begin
            fwd_sel_o = FWD_EXM;
        end else if (mem_hit_o) begin
            fwd_sel_o = FWD_MWB;
        end
    end

    logic unused_bits;
    assign unused_bits = ^{mem_i.is_load, wb_i.is_load};
`else
    assign fwd_sel_o = FWD_RF;

    logic unused_bits;
    assign unused_bits = ^{ex_i.is_load, mem_i.is_load, wb_i.is_load};
`endif

endmodule

// File: rtl/hazard_ctrl.sv
// Decode-stage hazard detection: tracks EX/MEM/WB writers, stalls decode and selects forwarding.
// Latency: stall/issue/fwd are combinational (zero cycles); slot state and stall_cnt update on clk.
// Backpressure: mem_stall freezes all slots and the counter; flush kills decode and injects a bubble.
// Build option: HAZARD_FORWARD_EN (defined: load-use stall only + forwarding; undefined: stall on any in-flight writer).
module hazard_ctrl
    import hazard_ctrl_pkg::*;
(
    input  logic             clk,
    input  logic             rst_n,
    input  logic             id_valid,
    input  logic [REG_W-1:0] id_rs,
    input  logic [REG_W-1:0] id_rt,
    input  logic             id_rs_used,
    input  logic             id_rt_used,
    input  logic [REG_W-1:0] id_wr,
    input  logic             id_wr_en,
    input  logic             id_is_load,
    input  logic             flush,
    input  logic             mem_stall,
    output logic             stall,
    output logic             issue,
    output logic [1:0]       fwd_a_sel,
    output logic [1:0]       fwd_b_sel,
    output logic [15:0]      stall_cnt
);

    slot_t ex_q, mem_q, wb_q;
    slot_t ex_d, mem_d, wb_d;
    logic [15:0] stall_cnt_q, stall_cnt_d;

    logic a_ex, a_mem, a_wb, b_ex, b_mem, b_wb;
    logic [1:0] a_sel, b_sel;
    logic hazard, stall_int, issue_int;

    hazard_src_match u_match_rs (
        .src_i     (id_rs),
        .used_i    (id_rs_used),
        .ex_i      (ex_q),
        .mem_i     (mem_q),
        .wb_i      (wb_q),
        .ex_hit_o  (a_ex),
        .mem_hit_o (a_mem),
        .wb_hit_o  (a_wb),
        .fwd_sel_o (a_sel)
    );

    hazard_src_match u_match_rt (
        .src_i     (id_rt),
        .used_i    (id_rt_used),
        .ex_i      (ex_q),
        .mem_i     (mem_q),
        .wb_i      (wb_q),
        .ex_hit_o  (b_ex),
        .mem_hit_o (b_mem),
        .wb_hit_o  (b_wb),
        .fwd_sel_o (b_sel)
    );

`ifdef HAZARD_FORWARD_EN
    // Everything except a load still in EX can be forwarded.
    assign hazard = ex_q.is_load & (a_ex | b_ex);
`else
    // No forwarding and no regfile write-through: any in-flight writer blocks the read.
    assign hazard = a_ex | a_mem | a_wb | b_ex | b_mem | b_wb;
`endif

    assign stall_int = id_valid & ~flush & hazard;
    assign issue_int = id_valid & ~stall_int & ~flush & ~mem_stall;

    // Outputs are forced quiet while reset is held, even if decode shows a valid instruction.
    assign stall     = rst_n & stall_int;
    assign issue     = rst_n & issue_int;
    assign fwd_a_sel = rst_n ? a_sel : FWD_RF;
    assign fwd_b_sel = rst_n ? b_sel : FWD_RF;
    assign stall_cnt = stall_cnt_q;

    // Next-state: slots shift toward WB unless memory freezes the pipe; EX takes decode or a bubble.
    always_comb begin
        ex_d        = ex_q;
        mem_d       = mem_q;
        wb_d        = wb_q;
        stall_cnt_d = stall_cnt_q;
        if (!mem_stall) begin
            wb_d  = mem_q;
            mem_d = ex_q;
            ex_d  = '0;
            if (issue_int) begin
                ex_d.valid   = 1'b1;
                ex_d.wr_en   = id_wr_en;
                ex_d.wr      = id_wr;
                ex_d.is_load = id_is_load;
            end
            if (stall_int && (stall_cnt_q != 16'hFFFF)) begin
                stall_cnt_d = stall_cnt_q + 16'd1;
            end
        end
    end

    // Slot and counter registers; reset drops everything in flight.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ex_q        <= '0;
            mem_q       <= '0;
            wb_q        <= '0;
            stall_cnt_q <= '0;
        end else begin
            ex_q        <= ex_d;
            mem_q       <= mem_d;
            wb_q        <= wb_d;
            stall_cnt_q <= stall_cnt_d;
        end
    end

    logic unused_bits;
    assign unused_bits = ^{a_mem, a_wb, b_mem, b_wb, mem_q.is_load, wb_q.is_load};

endmodule

// File: tb/tb_hazard_ctrl.sv
// Self-checking bench for hazard_ctrl: directed scenarios then random traffic vs. a history model.
// Latency: checks combinational outputs 1 time unit after inputs change on the falling edge.
// Backpressure: exercises mem_stall freeze, flush and mid-cycle asynchronous reset.
module tb_hazard_ctrl;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        id_valid;
    logic [2:0]  id_rs, id_rt, id_wr;
    logic        id_rs_used, id_rt_used, id_wr_en, id_is_load;
    logic        flush, mem_stall;
    logic        stall, issue;
    logic [1:0]  fwd_a_sel, fwd_b_sel;
    logic [15:0] stall_cnt;

    int total = 0;
    int bad   = 0;

    hazard_ctrl dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .id_valid   (id_valid),
        .id_rs      (id_rs),
        .id_rt      (id_rt),
        .id_rs_used (id_rs_used),
        .id_rt_used (id_rt_used),
        .id_wr      (id_wr),
        .id_wr_en   (id_wr_en),
        .id_is_load (id_is_load),
        .flush      (flush),
        .mem_stall  (mem_stall),
        .stall      (stall),
        .issue      (issue),
        .fwd_a_sel  (fwd_a_sel),
        .fwd_b_sel  (fwd_b_sel),
        .stall_cnt  (stall_cnt)
    );

    always #5 clk = ~clk;

    // Reference model: history of what entered EX on each advancing cycle, youngest first.
    typedef struct {
        bit          v;
        bit          we;
        int unsigned wr;
        bit          ld;
    } ins_t;

    ins_t hist[$];
    int   m_cnt;
    bit   e_stall, e_issue;
    int   e_fa, e_fb;

    function automatic bit hits(int age, bit used, int unsigned r);
        return used && hist[age].v && hist[age].we && (hist[age].wr == r);
    endfunction

    function automatic int fsel(bit used, int unsigned r);
`ifdef HAZARD_FORWARD_EN
        if (hits(0, used, r) && !hist[0].ld) return 1;
        if (hits(1, used, r)) return 2;
        return 0;
`else
        return (used && r > 99) ? 1 : 0;
`endif
    endfunction

    function automatic bit src_blocks(bit used, int unsigned r);
`ifdef HAZARD_FORWARD_EN
        return hits(0, used, r) && hist[0].ld;
`else
        bit any = 0;
        for (int age = 0; age < 3; age++) any |= hits(age, used, r);
        return any;
`endif
    endfunction

    task automatic model_reset();
        ins_t b;
        b = '{v: 0, we: 0, wr: 0, ld: 0};
        hist.delete();
        for (int i = 0; i < 3; i++) hist.push_back(b);
        m_cnt = 0;
    endtask

    task automatic model_eval();
        bit haz;
        if (!rst_n) begin
            e_stall = 0; e_issue = 0; e_fa = 0; e_fb = 0;
        end else begin
            haz     = src_blocks(id_rs_used, id_rs) || src_blocks(id_rt_used, id_rt);
            e_stall = id_valid && !flush && haz;
            e_issue = id_valid && !e_stall && !flush && !mem_stall;
            e_fa    = fsel(id_rs_used, id_rs);
            e_fb    = fsel(id_rt_used, id_rt);
        end
    endtask

    task automatic model_commit();
        ins_t n;
        if (!rst_n || mem_stall) return;
        if (e_issue) n = '{v: 1, we: id_wr_en, wr: id_wr, ld: id_is_load};
        else         n = '{v: 0, we: 0, wr: 0, ld: 0};
        hist.push_front(n);
        void'(hist.pop_back());
        if (e_stall && m_cnt < 65535) m_cnt++;
    endtask

    task automatic chk(string tag, logic [31:0] obs, logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic chk_model(string tag);
        chk({tag, ".stall"}, {31'd0, stall}, {31'd0, e_stall});
        chk({tag, ".issue"}, {31'd0, issue}, {31'd0, e_issue});
        chk({tag, ".fwd_a"}, {30'd0, fwd_a_sel}, e_fa);
        chk({tag, ".fwd_b"}, {30'd0, fwd_b_sel}, e_fb);
        chk({tag, ".cnt"},   {16'd0, stall_cnt}, m_cnt);
    endtask

    // One decode cycle: drive on the falling edge, check against the model, then commit the model.
    task automatic cyc(string tag, bit v, int rs, bit ru, int rt, bit tu,
                       int wr, bit we, bit ld, bit fl, bit ms);
        @(negedge clk);
        id_valid = v;   id_rs = 3'(rs); id_rs_used = ru; id_rt = 3'(rt); id_rt_used = tu;
        id_wr = 3'(wr); id_wr_en = we;  id_is_load = ld; flush = fl;     mem_stall = ms;
        #1;
        model_eval();
        chk_model(tag);
        model_commit();
    endtask

    task automatic idle3();
        for (int i = 0; i < 3; i++) cyc("idle", 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    endtask

    initial begin
        int cnt_before;
        model_reset();
        rst_n = 0;
        id_valid = 1; id_rs = 0; id_rt = 0; id_rs_used = 1; id_rt_used = 0;
        id_wr = 0; id_wr_en = 0; id_is_load = 0; flush = 0; mem_stall = 0;
        #2;
        chk("rst.stall", {31'd0, stall}, 0);
        chk("rst.issue", {31'd0, issue}, 0);
        chk("rst.fwd_a", {30'd0, fwd_a_sel}, 0);
        chk("rst.cnt",   {16'd0, stall_cnt}, 0);
        @(negedge clk); rst_n = 1;
        idle3();

        // Writer R3 then an unrelated reader of R5.
        cyc("nohaz.w", 1, 0, 0, 0, 0, 3, 1, 0, 0, 0);
        cyc("nohaz.r", 1, 5, 1, 0, 0, 6, 1, 0, 0, 0);
        chk("nohaz.stall", {31'd0, stall}, 0);
        chk("nohaz.issue", {31'd0, issue}, 1);
        chk("nohaz.fwd_a", {30'd0, fwd_a_sel}, 0);
        idle3();

`ifdef HAZARD_FORWARD_EN
        // Load R4, then rt=R4: one stall then issue forwarded from MEM/WB.
        cyc("ldu.w", 1, 0, 0, 0, 0, 4, 1, 1, 0, 0);
        cyc("ldu.r1", 1, 0, 0, 4, 1, 0, 0, 0, 0, 0);
        chk("ldu.stall1", {31'd0, stall}, 1);
        cyc("ldu.r2", 1, 0, 0, 4, 1, 0, 0, 0, 0, 0);
        chk("ldu.issue", {31'd0, issue}, 1);
        chk("ldu.fwd_b", {30'd0, fwd_b_sel}, 2);
        idle3();
        // Two ALU writers of R1, then a reader: youngest (EX/MEM) wins.
        cyc("alu.w1", 1, 0, 0, 0, 0, 1, 1, 0, 0, 0);
        cyc("alu.w2", 1, 0, 0, 0, 0, 1, 1, 0, 0, 0);
        cyc("alu.r",  1, 1, 1, 0, 0, 0, 0, 0, 0, 0);
        chk("alu.fwd_a", {30'd0, fwd_a_sel}, 1);
        chk("alu.stall", {31'd0, stall}, 0);
        idle3();
`else
        // Writer R2 then rs=R2: three stalls, issue on the fourth cycle.
        cnt_before = m_cnt;
        cyc("raw.w", 1, 0, 0, 0, 0, 2, 1, 0, 0, 0);
        for (int i = 0; i < 3; i++) begin
            cyc("raw.r", 1, 2, 1, 0, 0, 0, 0, 0, 0, 0);
            chk("raw.stall", {31'd0, stall}, 1);
        end
        cyc("raw.r4", 1, 2, 1, 0, 0, 0, 0, 0, 0, 0);
        chk("raw.issue4", {31'd0, issue}, 1);
        chk("raw.cnt", {16'd0, stall_cnt}, cnt_before + 3);
        idle3();
`endif

        // Flush during a load-use stall kills decode and puts a bubble in EX.
        cyc("fl.w", 1, 0, 0, 0, 0, 6, 1, 1, 0, 0);
        cyc("fl.r", 1, 6, 1, 0, 0, 0, 0, 0, 0, 0);
        chk("fl.stalled", {31'd0, stall}, 1);
        cyc("fl.f", 1, 6, 1, 0, 0, 0, 0, 0, 1, 0);
        chk("fl.stall", {31'd0, stall}, 0);
        chk("fl.issue", {31'd0, issue}, 0);
        @(posedge clk); #1;
        chk("fl.ex_valid", {31'd0, dut.ex_q.valid}, 0);
        idle3();

        // mem_stall while stalled freezes the counter; then an asynchronous reset mid-cycle.
        cyc("ms.w", 1, 0, 0, 0, 0, 7, 1, 1, 0, 0);
        cyc("ms.r", 1, 0, 0, 7, 1, 0, 0, 0, 0, 0);
        chk("ms.stalled", {31'd0, stall}, 1);
        cnt_before = m_cnt;
        for (int i = 0; i < 2; i++) begin
            cyc("ms.hold", 1, 0, 0, 7, 1, 0, 0, 0, 0, 1);
            chk("ms.stall", {31'd0, stall}, 1);
            chk("ms.cnt", {16'd0, stall_cnt}, cnt_before);
        end
        @(negedge clk);
        mem_stall = 0;
        #2 rst_n = 0;
        #1;
        chk("arst.stall", {31'd0, stall}, 0);
        chk("arst.issue", {31'd0, issue}, 0);
        chk("arst.fwd_a", {30'd0, fwd_a_sel}, 0);
        chk("arst.fwd_b", {30'd0, fwd_b_sel}, 0);
        chk("arst.cnt",   {16'd0, stall_cnt}, 0);
        model_reset();
        @(negedge clk); rst_n = 1;
        cyc("arst.after", 1, 0, 0, 7, 1, 0, 0, 0, 0, 0);
        chk("arst.nostall", {31'd0, stall}, 0);

        // Random traffic on a small register window to provoke frequent hazards.
        for (int i = 0; i < 600; i++) begin
            cyc("rnd",
                ($urandom_range(0, 9) < 8), $urandom_range(0, 3), $urandom_range(0, 1),
                $urandom_range(0, 3), $urandom_range(0, 1), $urandom_range(0, 3),
                $urandom_range(0, 1), ($urandom_range(0, 2) == 0),
                ($urandom_range(0, 9) == 0), ($urandom_range(0, 5) == 0));
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
